// File: rtl/timing_recovery_loop_if.sv
// Sample/strobe bundle between the matched filter, the timing loop and its consumers.
// The master drives the i_* side, the loop (slave) drives the o_* side.
interface timing_recovery_loop_if #(
    parameter int NB_DATA  = 9,
    parameter int NB_ERR   = 20,
    parameter int NB_PHASE = 4
);
    logic                       i_valid;
    logic signed [NB_DATA-1:0]  i_data;
    logic                       i_mode;
    logic [4:0]                 i_kp_shift;
    logic [4:0]                 i_ki_shift;
    logic [NB_ERR-1:0]          i_lock_thr;
    logic                       i_freeze;
    logic signed [NB_DATA-1:0]  o_sym;
    logic                       o_sym_valid;
    logic signed [NB_ERR-1:0]   o_ted;
    logic                       o_ted_valid;
    logic [NB_PHASE-1:0]        o_phase;
    logic                       o_stuff;
    logic                       o_skip;
    logic                       o_lock;

    modport master (
        output i_valid, i_data, i_mode, i_kp_shift, i_ki_shift, i_lock_thr, i_freeze,
        input  o_sym, o_sym_valid, o_ted, o_ted_valid, o_phase, o_stuff, o_skip, o_lock
    );

    modport slave (
        input  i_valid, i_data, i_mode, i_kp_shift, i_ki_shift, i_lock_thr, i_freeze,
        output o_sym, o_sym_valid, o_ted, o_ted_valid, o_phase, o_stuff, o_skip, o_lock
    );
endinterface

// File: rtl/timing_recovery_loop.sv
// Closed-loop symbol timing recovery: Gardner / ML early-late TED, PI loop filter,
// fractional phase accumulator with stuff/skip control and a windowed lock detector.
module timing_recovery_loop #(
    parameter int NB_DATA     = 9,
    parameter int NBF_DATA    = 7,
    parameter int OS          = 2,
    parameter int NB_PHASE    = 4,
    parameter int NB_ERR      = 20,
    parameter int NB_MU       = 22,
    parameter int NB_LOCK_WIN = 6
) (
    input  logic clk,
    input  logic rst_n,
    timing_recovery_loop_if.slave bus
);
    localparam int CW     = $clog2(OS + 1);
    localparam int PW     = 2 * NB_DATA + 2;
    localparam int IW     = NB_MU + 2;
    localparam int MW     = (PW > IW) ? PW : IW;
    localparam int WW     = ((MW > NB_ERR) ? MW : NB_ERR) + 2;
    localparam int AW     = NB_ERR + NB_LOCK_WIN;
    localparam int TED_SH = (PW > NB_ERR) ? PW - NB_ERR : 0;

    localparam logic signed [WW-1:0] E_MAX = {{(WW-NB_ERR+1){1'b0}}, {(NB_ERR-1){1'b1}}};
    localparam logic signed [WW-1:0] E_MIN = ~E_MAX;
    localparam logic signed [WW-1:0] I_MAX = {{(WW-IW+1){1'b0}}, {(IW-1){1'b1}}};
    localparam logic signed [WW-1:0] I_MIN = ~I_MAX;

    localparam logic [1:0] P_NONE  = 2'd0;
    localparam logic [1:0] P_STUFF = 2'd1;
    localparam logic [1:0] P_SKIP  = 2'd2;

    if (OS < 2 || OS > 8 || (OS & (OS - 1)) != 0 || NBF_DATA >= NB_DATA) begin : g_param_check
        $error("timing_recovery_loop: unsupported OS or NBF_DATA");
    end

    function automatic logic signed [NB_ERR-1:0] sat_e(input logic signed [WW-1:0] x);
        if (x > E_MAX) return E_MAX[NB_ERR-1:0];
        if (x < E_MIN) return E_MIN[NB_ERR-1:0];
        return x[NB_ERR-1:0];
    endfunction

    function automatic logic signed [IW-1:0] sat_i(input logic signed [WW-1:0] x);
        if (x > I_MAX) return I_MAX[IW-1:0];
        if (x < I_MIN) return I_MIN[IW-1:0];
        return x[IW-1:0];
    endfunction

    logic signed [NB_DATA-1:0] h [0:OS];
    logic signed [NB_DATA-1:0] sym_r;
    logic [CW-1:0]             cnt, term;
    logic [1:0]                pend, queued, pend_c, queued_c, wrap;
    logic [1:0]                prime;
    logic                      eot, mode_r, sym_v, ted_v, upd, stuff_r, skip_r, lock_r;
    logic signed [PW-1:0]      a, b, prod;
    logic signed [WW-1:0]      e_full, t_e, t_i, t_n;
    logic signed [NB_ERR-1:0]  e_sat, ted;
    logic signed [IW-1:0]      integ, integ_c, ctrl, ctrl_c, sum;
    logic [NB_MU-1:0]          mu;
    logic [NB_ERR-1:0]         mag;
    logic [AW-1:0]             acc, acc_c;
    logic [NB_LOCK_WIN-1:0]    win;

    // A pending stuff stretches the current symbol by one sample, a skip shortens it.
    always_comb begin
        case (pend)
            P_STUFF: term = CW'(OS);
            P_SKIP:  term = CW'(OS - 2);
            default: term = CW'(OS - 1);
        endcase
    end

    assign eot = bus.i_valid && (cnt >= term);

    // Evaluated in the cycle after the on-time sample, when h[0] holds it.
    always_comb begin
        a = h[OS/2];
        if (mode_r) begin
            b    = h[OS] - h[0];
            prod = a * b;
        end else begin
            b    = h[0] - h[2];
            prod = h[1][NB_DATA-1] ? -b : b;
        end
        e_full = prod;
        e_sat  = sat_e(e_full >>> TED_SH);
    end

    always_comb begin
        t_e     = ted;
        t_i     = integ;
        integ_c = sat_i(t_i + (t_e >>> bus.i_ki_shift));
        t_n     = bus.i_freeze ? integ : integ_c;
        ctrl_c  = sat_i((t_e >>> bus.i_kp_shift) + t_n);
        sum     = $signed({2'b00, mu}) + ctrl;
    end

    // One adjustment is live at a time; a wrap arriving while one is live waits a symbol.
    always_comb begin
        pend_c   = eot ? queued : pend;
        queued_c = eot ? P_NONE : queued;
        wrap     = P_NONE;
        if (upd && !bus.i_freeze)
            wrap = sum[IW-1] ? P_SKIP : (sum[IW-2] ? P_STUFF : P_NONE);
        if (wrap != P_NONE) begin
            if (pend_c == P_NONE) pend_c = wrap;
            else                  queued_c = wrap;
        end
    end

    always_comb begin
        mag   = ted[NB_ERR-1] ? -ted : ted;
        acc_c = acc + AW'(mag);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= OS; i++) h[i] <= '0;
            cnt     <= '0;
            mode_r  <= 1'b0;
            sym_r   <= '0;
            sym_v   <= 1'b0;
            ted     <= '0;
            ted_v   <= 1'b0;
            prime   <= '0;
            upd     <= 1'b0;
            integ   <= '0;
            ctrl    <= '0;
            mu      <= '0;
            pend    <= P_NONE;
            queued  <= P_NONE;
            stuff_r <= 1'b0;
            skip_r  <= 1'b0;
            acc     <= '0;
            win     <= '0;
            lock_r  <= 1'b0;
        end else begin
            if (bus.i_valid) begin
                for (int unsigned i = OS; i > 0; i--) h[i] <= h[i-1];
                h[0] <= bus.i_data;
                cnt  <= eot ? '0 : cnt + CW'(1);
            end
            if (eot) begin
                mode_r <= bus.i_mode;
                sym_r  <= bus.i_data;
            end
            sym_v <= eot;
            ted_v <= sym_v;
            if (sym_v) begin
                ted <= (prime == 2'd2) ? e_sat : '0;
                if (prime != 2'd2) prime <= prime + 2'd1;
            end
            if (ted_v) begin
                if (!bus.i_freeze) integ <= integ_c;
                ctrl <= ctrl_c;
                win  <= win + NB_LOCK_WIN'(1);
                if (&win) begin
                    lock_r <= (acc_c >> NB_LOCK_WIN) < AW'(bus.i_lock_thr);
                    acc    <= '0;
                end else begin
                    acc <= acc_c;
                end
            end
            upd <= ted_v;
            if (upd && !bus.i_freeze) mu <= sum[NB_MU-1:0];
            stuff_r <= (wrap == P_STUFF);
            skip_r  <= (wrap == P_SKIP);
            pend    <= pend_c;
            queued  <= queued_c;
        end
    end

    assign bus.o_sym       = sym_r;
    assign bus.o_sym_valid = sym_v;
    assign bus.o_ted       = ted;
    assign bus.o_ted_valid = ted_v;
    assign bus.o_phase     = mu[NB_MU-1 -: NB_PHASE];
    assign bus.o_stuff     = stuff_r;
    assign bus.o_skip      = skip_r;
    assign bus.o_lock      = lock_r;
endmodule

// File: tb/tb_timing_recovery_loop.sv
// Directed bench for timing_recovery_loop: TED vector table plus lock, wrap, freeze and reset sequences.
module tb_timing_recovery_loop;
    logic clk = 1'b0;
    logic rst_n;
    int   errors, checks;

    always #5 clk = ~clk;

    timing_recovery_loop_if #(.NB_DATA(9), .NB_ERR(20), .NB_PHASE(4)) ifc ();

    timing_recovery_loop #(
        .NB_DATA(9), .NBF_DATA(7), .OS(2), .NB_PHASE(4),
        .NB_ERR(20), .NB_MU(22), .NB_LOCK_WIN(6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(ifc)
    );

    typedef struct {
        logic mode;
        int   mid;
        int   on;
        int   ted;
    } vec_t;

    vec_t tbl [12];

    logic signed [19:0] ted_q [$];
    logic signed [8:0]  sym_q [$];
    int                 span_q [$];
    int                 stuff_cnt, skip_cnt, vcnt;

    always @(negedge clk) begin
        if (!rst_n) begin
            vcnt = 0;
        end else begin
            if (ifc.o_sym_valid) begin
                sym_q.push_back(ifc.o_sym);
                span_q.push_back(vcnt);
                vcnt = 0;
            end
            if (ifc.o_ted_valid) ted_q.push_back(ifc.o_ted);
            if (ifc.o_stuff) stuff_cnt++;
            if (ifc.o_skip) skip_cnt++;
            if (ifc.i_valid) vcnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        ted_q.delete();
        sym_q.delete();
        span_q.delete();
        stuff_cnt = 0;
        skip_cnt  = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifc.i_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        clear_mon();
    endtask

    task automatic send(input int x);
        ifc.i_valid = 1'b1;
        ifc.i_data  = 9'(x);
        tick();
        ifc.i_valid = 1'b0;
        repeat (5) tick();
    endtask

    task automatic send_sym(input logic m, input int mid, input int on);
        ifc.i_mode = m;
        send(mid);
        send(on);
    endtask

    function automatic int alt(input int k);
        return (k % 2 == 1) ? 127 : -127;
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        clear_mon();
        ifc.i_valid = 1'b0;
        ifc.i_data = '0;
        ifc.i_mode = 1'b1;
        ifc.i_kp_shift = 5'd31;
        ifc.i_ki_shift = 5'd31;
        ifc.i_lock_thr = 20'd1;
        ifc.i_freeze = 1'b1;

        // Gardner rows then ML rows; expected e = mid*(prev_on - on) or sign(mid)*(on - prev_on)
        tbl[0]  = '{1'b1,    0,  127,     0};
        tbl[1]  = '{1'b1,    0, -127,     0};
        tbl[2]  = '{1'b1,    3,  127,  -762};
        tbl[3]  = '{1'b1,   20, -127,  5080};
        tbl[4]  = '{1'b1,  -30,  127,  7620};
        tbl[5]  = '{1'b1,   50,  100,  1350};
        tbl[6]  = '{1'b0,   10, -100,  -200};
        tbl[7]  = '{1'b0,   -5,   60,  -160};
        tbl[8]  = '{1'b0,    0, -128,  -188};
        tbl[9]  = '{1'b1, -128,  127, 32640};
        tbl[10] = '{1'b1,  127, -128, 32385};
        tbl[11] = '{1'b0,   -1,  127,  -255};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ifc.i_valid = (i != 1);
            ifc.i_data  = 9'sd100;
            tick();
        end
        chk("rst_sym_valid", ifc.o_sym_valid, 0);
        chk("rst_ted_valid", ifc.o_ted_valid, 0);
        chk("rst_flags", {ifc.o_stuff, ifc.o_skip, ifc.o_lock}, 0);
        chk("rst_phase", ifc.o_phase, 0);
        chk("rst_sym", ifc.o_sym, 0);
        chk("rst_ted", ifc.o_ted, 0);
        ifc.i_valid = 1'b0;
        rst_n = 1'b1;
        clear_mon();
        tick();
        send(0);
        chk("first_sym_early", sym_q.size(), 0);
        send(127);
        chk("first_sym_count", sym_q.size(), 1);
        chk("first_sym_span", (span_q.size() > 0) ? span_q[0] : -1, 2);

        do_reset();
        for (int i = 0; i < 12; i++) send_sym(tbl[i].mode, tbl[i].mid, tbl[i].on);
        chk("tbl_ted_count", ted_q.size(), 12);
        chk("tbl_sym_count", sym_q.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < ted_q.size()) chk($sformatf("tbl_ted_%0d", i), ted_q[i], tbl[i].ted);
            if (i < sym_q.size()) chk($sformatf("tbl_sym_%0d", i), sym_q[i], tbl[i].on);
        end
        chk("tbl_no_wrap", stuff_cnt + skip_cnt, 0);
        chk("tbl_phase", ifc.o_phase, 0);

        do_reset();
        for (int k = 1; k <= 63; k++) send_sym(1'b1, 0, alt(k));
        chk("lock_before_window", ifc.o_lock, 0);
        send_sym(1'b1, 0, alt(64));
        chk("lock_after_window", ifc.o_lock, 1);
        for (int k = 65; k <= 127; k++) send_sym(1'b1, -alt(k), alt(k));
        chk("lock_held_mid_window", ifc.o_lock, 1);
        send_sym(1'b1, -alt(128), alt(128));
        chk("lock_lost", ifc.o_lock, 0);
        chk("lock_bad_ted", (ted_q.size() > 0) ? ted_q[$] : 0, 32258);

        // Constant e=32258 with kp=ki=1: mu = e*n(n+3)/2 crosses 2^22 at n=15 (symbol 17)
        do_reset();
        ifc.i_freeze = 1'b0;
        ifc.i_kp_shift = 5'd0;
        ifc.i_ki_shift = 5'd0;
        for (int k = 1; k <= 16; k++) send_sym(1'b1, -alt(k), alt(k));
        chk("stuff_pre_phase", ifc.o_phase, 14);
        chk("stuff_pre_count", stuff_cnt, 0);
        send_sym(1'b1, -alt(17), alt(17));
        chk("stuff_count", stuff_cnt, 1);
        chk("stuff_phase", ifc.o_phase, 0);
        begin
            int n0;
            n0 = span_q.size();
            send(0);
            send(0);
            chk("stuff_span_open", span_q.size(), n0);
            send(0);
            chk("stuff_span_count", span_q.size(), n0 + 1);
            chk("stuff_span_len", (span_q.size() > 0) ? span_q[$] : -1, 3);
            send(0);
            send(0);
            chk("stuff_next_span", (span_q.size() > 0) ? span_q[$] : -1, 2);
            chk("stuff_single", stuff_cnt + skip_cnt, 1);
        end

        // Negative e on the first live symbol drives mu below zero immediately
        do_reset();
        for (int k = 1; k <= 3; k++) send_sym(1'b1, alt(k), alt(k));
        chk("skip_count", skip_cnt, 1);
        chk("skip_no_stuff", stuff_cnt, 0);
        chk("skip_phase", ifc.o_phase, 15);
        begin
            int n0;
            n0 = span_q.size();
            send(0);
            chk("skip_span_count", span_q.size(), n0 + 1);
            chk("skip_span_len", (span_q.size() > 0) ? span_q[$] : -1, 1);
            send(0);
            send(0);
            chk("skip_next_span", (span_q.size() > 0) ? span_q[$] : -1, 2);
        end

        ifc.i_freeze = 1'b1;
        for (int k = 1; k <= 4; k++) send_sym(1'b1, -alt(k), alt(k));
        chk("freeze_phase", ifc.o_phase, 15);
        chk("freeze_no_wrap", stuff_cnt * 10 + skip_cnt, 1);
        chk("freeze_ted_runs", (ted_q.size() > 0) ? ted_q[$] : 0, 32258);
        ifc.i_freeze = 1'b0;
        send_sym(1'b1, 0, 0);
        send_sym(1'b1, 0, 0);
        chk("unfreeze_phase", ifc.o_phase, 15);
        chk("unfreeze_no_wrap", stuff_cnt * 10 + skip_cnt, 1);

        send(10);
        clear_mon();
        rst_n = 1'b0;
        ifc.i_valid = 1'b1;
        ifc.i_data = 9'sd50;
        tick();
        rst_n = 1'b1;
        ifc.i_valid = 1'b0;
        repeat (6) tick();
        chk("midrst_no_strobe", sym_q.size() + ted_q.size(), 0);
        chk("midrst_phase", ifc.o_phase, 0);
        chk("midrst_lock", ifc.o_lock, 0);
        send(1);
        chk("midrst_first_early", sym_q.size(), 0);
        send(2);
        chk("midrst_first_sym", sym_q.size(), 1);
        chk("midrst_sym_val", (sym_q.size() > 0) ? sym_q[0] : 0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
